// File: rtl/level_sequencer.sv
// level_sequencer: level/round controller for the number-guessing game.
// Owns round timer, guess and round counters; publishes per-level limits.
//
// Ports:
//   clk          system clock
//   restart      asynchronous active-low reset
//   start        pulse, begins a game from IDLE, WIN or GAMEOVER
//   tick         1 Hz enable, decrements the round timer
//   confirm      pulse, player committed a guess
//   correct      guess matched, only meaningful with confirm
//   state        IDLE=0, PLAY=1, WIN=2, GAMEOVER=3
//   level        current level 1..NUM_LEVELS, 0 outside PLAY
//   max_timer    TIME_STEP*level in PLAY, else 0
//   max_guess    GUESS_BASE+level in PLAY, else 0
//   max_digit    level in PLAY, else 0
//   time_left    seconds left in the round
//   guesses_left guesses left in the round
//   round_cnt    rounds cleared in the current level
//   round_done   one-cycle pulse when a round is cleared
module level_sequencer #(
   parameter int NUM_LEVELS       = 3,
   parameter int ROUNDS_PER_LEVEL = 3,
   parameter int TIME_STEP        = 30,
   parameter int GUESS_BASE       = 2,
   parameter int TIMER_W          = 7,
   parameter int GUESS_W          = 4,
   parameter int LEVEL_W          = 2
) (
   input  logic               clk,
   input  logic               restart,
   input  logic               start,
   input  logic               tick,
   input  logic               confirm,
   input  logic               correct,
   output logic [2:0]         state,
   output logic [LEVEL_W-1:0] level,
   output logic [TIMER_W-1:0] max_timer,
   output logic [GUESS_W-1:0] max_guess,
   output logic [LEVEL_W-1:0] max_digit,
   output logic [TIMER_W-1:0] time_left,
   output logic [GUESS_W-1:0] guesses_left,
   output logic [LEVEL_W-1:0] round_cnt,
   output logic               round_done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PLAY     = 3'd1,
      WIN      = 3'd2,
      GAMEOVER = 3'd3
   } st_t;

   localparam int LUT_N = 2 ** LEVEL_W;

   st_t st;

   // Per-level round time, elaborated as constants so no multiplier
   // is built. Entries past NUM_LEVELS are unreachable and held at 0.
   logic [TIMER_W-1:0] tlut [LUT_N];

   genvar gi;
   generate
      for (gi = 0; gi < LUT_N; gi++) begin : g_lut
         if (gi <= NUM_LEVELS) begin : g_used
            assign tlut[gi] = TIMER_W'(TIME_STEP * gi);
         end else begin : g_unused
            assign tlut[gi] = '0;
         end
      end
   endgenerate

   function automatic logic [GUESS_W-1:0] glim(
      input logic [LEVEL_W-1:0] l
   );
      return GUESS_W'(GUESS_BASE) + GUESS_W'(l);
   endfunction

   logic               in_play;
   logic [LEVEL_W-1:0] nxt_lvl;
   logic               more_rounds;
   logic               more_levels;
   logic               g_out;
   logic               t_out;
   logic [GUESS_W-1:0] g_dec;
   logic [TIMER_W-1:0] t_dec;

   assign state       = st;
   assign in_play     = (st == PLAY);
   assign nxt_lvl     = level + LEVEL_W'(1);
   assign more_rounds = (32'(round_cnt) + 32'd1)
                        < 32'(ROUNDS_PER_LEVEL);
   assign more_levels = 32'(level) < 32'(NUM_LEVELS);

   // Terminating events: the counter was at 1 and is about to hit 0.
   assign g_out = confirm && (guesses_left == GUESS_W'(1));
   assign t_out = tick && (time_left == TIMER_W'(1));

   // Saturating decrements.
   assign g_dec = (guesses_left == '0) ? '0
                : guesses_left - GUESS_W'(1);
   assign t_dec = (time_left == '0) ? '0
                : time_left - TIMER_W'(1);

   assign max_timer = in_play ? tlut[level] : '0;
   assign max_guess = in_play ? glim(level) : '0;
   assign max_digit = in_play ? level : '0;

   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         st           <= IDLE;
         level        <= '0;
         time_left    <= '0;
         guesses_left <= '0;
         round_cnt    <= '0;
         round_done   <= 1'b0;
      end else begin
         round_done <= 1'b0;
         case (st)
            PLAY: begin
               if (confirm && correct) begin
                  // A same-cycle tick is dropped: the round reloads.
                  round_done <= 1'b1;
                  if (more_rounds) begin
                     round_cnt    <= round_cnt + LEVEL_W'(1);
                     time_left    <= tlut[level];
                     guesses_left <= glim(level);
                  end else if (more_levels) begin
                     level        <= nxt_lvl;
                     round_cnt    <= '0;
                     time_left    <= tlut[nxt_lvl];
                     guesses_left <= glim(nxt_lvl);
                  end else begin
                     st    <= WIN;
                     level <= '0;
                  end
               end else begin
                  // Wrong guess and tick may both land this cycle.
                  if (confirm) guesses_left <= g_dec;
                  if (tick)    time_left    <= t_dec;
                  if (g_out || t_out) begin
                     st    <= GAMEOVER;
                     level <= '0;
                  end
               end
            end
            default: begin
               if (start) begin
                  st           <= PLAY;
                  level        <= LEVEL_W'(1);
                  round_cnt    <= '0;
                  time_left    <= tlut[1];
                  guesses_left <= glim(LEVEL_W'(1));
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: vector table, directed corner cases and a
// randomized run against a spec-level reference model.
module tb_level_sequencer;

   localparam int NL = 3;
   localparam int RP = 3;
   localparam int TS = 30;
   localparam int GB = 2;

   logic clk = 1'b0;
   logic restart = 1'b0;
   logic start = 1'b0, tick = 1'b0;
   logic confirm = 1'b0, correct = 1'b0;
   logic [2:0] state;
   logic [1:0] level, max_digit, round_cnt;
   logic [6:0] max_timer, time_left;
   logic [3:0] max_guess, guesses_left;
   logic       round_done;

   logic start2 = 1'b0, tick2 = 1'b0;
   logic confirm2 = 1'b0, correct2 = 1'b0;
   logic [2:0] state2;
   logic [2:0] level2, max_digit2, round_cnt2;
   logic [5:0] max_timer2, time_left2;
   logic [3:0] max_guess2, guesses_left2;
   logic       round_done2;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   level_sequencer dut (
      .clk(clk), .restart(restart), .start(start),
      .tick(tick), .confirm(confirm), .correct(correct),
      .state(state), .level(level), .max_timer(max_timer),
      .max_guess(max_guess), .max_digit(max_digit),
      .time_left(time_left), .guesses_left(guesses_left),
      .round_cnt(round_cnt), .round_done(round_done)
   );

   level_sequencer #(
      .NUM_LEVELS(4), .ROUNDS_PER_LEVEL(1), .TIME_STEP(15),
      .GUESS_BASE(2), .TIMER_W(6), .GUESS_W(4), .LEVEL_W(3)
   ) dut2 (
      .clk(clk), .restart(restart), .start(start2),
      .tick(tick2), .confirm(confirm2), .correct(correct2),
      .state(state2), .level(level2), .max_timer(max_timer2),
      .max_guess(max_guess2), .max_digit(max_digit2),
      .time_left(time_left2), .guesses_left(guesses_left2),
      .round_cnt(round_cnt2), .round_done(round_done2)
   );

   // Reference model: plain integers following the game rules.
   int m_st, m_lv, m_t, m_g, m_r, m_d;

   task automatic m_reset();
      m_st = 0; m_lv = 0; m_t = 0; m_g = 0; m_r = 0; m_d = 0;
   endtask

   task automatic m_load(input int l);
      m_t = TS * l;
      m_g = GB + l;
   endtask

   task automatic m_step(input bit s, t, c, k);
      bit over;
      m_d = 0;
      if (m_st == 1) begin
         if (c && k) begin
            m_d = 1;
            if (m_r + 1 < RP) begin
               m_r++;
               m_load(m_lv);
            end else if (m_lv < NL) begin
               m_lv++;
               m_r = 0;
               m_load(m_lv);
            end else begin
               m_st = 2;
               m_lv = 0;
            end
         end else begin
            over = 0;
            if (c) begin
               if (m_g == 1) over = 1;
               if (m_g > 0) m_g--;
            end
            if (t) begin
               if (m_t == 1) over = 1;
               if (m_t > 0) m_t--;
            end
            if (over) begin
               m_st = 3;
               m_lv = 0;
            end
         end
      end else if (s) begin
         m_st = 1; m_lv = 1; m_r = 0;
         m_load(1);
      end
   endtask

   function automatic logic [31:0] epack(
      input int st, lv, t, g, r, d
   );
      int mt, mg, md;
      mt = (st == 1) ? TS * lv : 0;
      mg = (st == 1) ? GB + lv : 0;
      md = (st == 1) ? lv : 0;
      return {3'(st), 2'(lv), 7'(mt), 4'(mg), 2'(md),
              7'(t), 4'(g), 2'(r), 1'(d)};
   endfunction

   function automatic logic [31:0] dpack();
      return {state, level, max_timer, max_guess, max_digit,
              time_left, guesses_left, round_cnt, round_done};
   endfunction

   function automatic logic [31:0] mpack();
      return epack(m_st, m_lv, m_t, m_g, m_r, m_d);
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      else
         passed++;
   endtask

   // Inputs are set before the edge and cleared 1 ns after it.
   task automatic step(input bit s, t, c, k);
      start = s; tick = t; confirm = c; correct = k;
      @(posedge clk); #1;
      start = 0; tick = 0; confirm = 0; correct = 0;
      m_step(s, t, c, k);
   endtask

   task automatic step2(input bit s, c, k);
      start2 = s; confirm2 = c; correct2 = k;
      @(posedge clk); #1;
      start2 = 0; confirm2 = 0; correct2 = 0;
      m_step(0, 0, 0, 0);
   endtask

   // Reset asserted between edges must clear outputs at once.
   task automatic do_reset(input string nm);
      restart = 1'b0;
      #2;
      chk(nm, dpack(), 32'd0);
      @(negedge clk);
      restart = 1'b1;
      m_reset();
   endtask

   typedef struct {
      bit s, t, c, k;
      int st, lv, tl, gl, rc, rd;
   } vec_t;

   vec_t vt[16];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int emt[9];
      int esw[5];

      vt[0]  = '{0,1,0,0, 0,0, 0,0,0,0};
      vt[1]  = '{0,0,1,1, 0,0, 0,0,0,0};
      vt[2]  = '{1,0,0,0, 1,1,30,3,0,0};
      vt[3]  = '{0,1,0,0, 1,1,29,3,0,0};
      vt[4]  = '{0,0,1,0, 1,1,29,2,0,0};
      vt[5]  = '{0,1,1,0, 1,1,28,1,0,0};
      vt[6]  = '{0,0,1,1, 1,1,30,3,1,1};
      vt[7]  = '{1,0,0,0, 1,1,30,3,1,0};
      vt[8]  = '{0,0,1,1, 1,1,30,3,2,1};
      vt[9]  = '{0,1,1,1, 1,2,60,4,0,1};
      vt[10] = '{0,0,1,0, 1,2,60,3,0,0};
      vt[11] = '{0,0,1,0, 1,2,60,2,0,0};
      vt[12] = '{0,0,1,0, 1,2,60,1,0,0};
      vt[13] = '{0,0,1,0, 3,0,60,0,0,0};
      vt[14] = '{0,1,0,0, 3,0,60,0,0,0};
      vt[15] = '{1,0,0,0, 1,1,30,3,0,0};

      m_reset();
      #3;
      chk("reset_init", dpack(), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      restart = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(vt[i].s, vt[i].t, vt[i].c, vt[i].k);
         chk($sformatf("vec%0d", i), dpack(),
             epack(vt[i].st, vt[i].lv, vt[i].tl,
                   vt[i].gl, vt[i].rc, vt[i].rd));
      end

      // Reset mid-round in level 2.
      do_reset("reset_pre");
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
      step(0, 1, 0, 0);
      chk("lvl2_before_reset", 32'(level), 32'd2);
      do_reset("reset_mid_play");

      // Full win with the default parameters.
      emt = '{30, 30, 60, 60, 60, 90, 90, 90, 0};
      pulses = 0;
      step(1, 0, 0, 0);
      chk("win_start_mt", 32'(max_timer), 32'd30);
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 1, 1);
         pulses += int'(round_done);
         chk($sformatf("win_rd%0d", i), dpack(), mpack());
         chk($sformatf("win_mt%0d", i), 32'(max_timer),
             32'(emt[i]));
      end
      chk("win_pulses", 32'(pulses), 32'd9);
      chk("win_state", 32'(state), 32'd2);
      step(0, 1, 1, 0);
      chk("win_frozen", dpack(), mpack());

      // Guess exhaustion at level 1.
      do_reset("reset_g");
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0);
         chk($sformatf("gx%0d", i), 32'(guesses_left),
             32'(2 - i));
      end
      chk("gx_state", 32'(state), 32'd3);
      step(0, 1, 0, 0);
      chk("gx_tick_frozen", 32'(time_left), 32'd30);

      // Timeout.
      do_reset("reset_t");
      step(1, 0, 0, 0);
      for (int i = 0; i < 29; i++) step(0, 1, 0, 0);
      chk("to_29", dpack(), epack(1, 1, 1, 3, 0, 0));
      step(0, 1, 0, 0);
      chk("to_30", dpack(), epack(3, 0, 0, 3, 0, 0));
      step(1, 0, 0, 0);
      chk("to_restart", dpack(), epack(1, 1, 30, 3, 0, 0));

      // Simultaneous events at time_left == 1.
      do_reset("reset_s");
      step(1, 0, 0, 0);
      for (int i = 0; i < 29; i++) step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      chk("sim_tick_ok", dpack(), epack(1, 1, 30, 3, 1, 1));
      for (int i = 0; i < 29; i++) step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      chk("sim_pre", dpack(), epack(1, 1, 1, 2, 1, 0));
      step(0, 1, 1, 0);
      chk("sim_tick_bad", dpack(), epack(3, 0, 0, 1, 1, 0));

      // Parameter sweep on the second instance.
      do_reset("reset_w");
      esw = '{15, 30, 45, 60, 0};
      step2(1, 0, 0);
      chk("sw_start", {23'd0, state2, max_timer2},
          {23'd0, 3'd1, 6'(esw[0])});
      for (int i = 1; i < 5; i++) begin
         step2(0, 1, 1);
         chk($sformatf("sw%0d", i), {23'd0, state2, max_timer2},
             {23'd0, (i == 4) ? 3'd2 : 3'd1, 6'(esw[i])});
      end

      // Randomized run against the model.
      do_reset("reset_r");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset("reset_rand");
         end else begin
            step($urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0);
            chk("rand", dpack(), mpack());
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Parametrised game-level controller for the number-guessing game. It sequences the player through `NUM_LEVELS` difficulty levels with `ROUNDS_PER_LEVEL` rounds each. It owns the per-round countdown timer, guess counter and round counter, and publishes the per-level limits (time, guesses, digits) to the datapath and display logic. It sits between the guess-comparison logic, which supplies `confirm`/`correct`, and the seven-segment/LED display drivers.

## Interface
- `NUM_LEVELS`, 3: number of difficulty levels, at least 1.
- `ROUNDS_PER_LEVEL`, 3: correct rounds needed to clear a level, at least 1.
- `TIME_STEP`, 30: timer seconds per level index; level L allows `TIME_STEP*L`.
- `GUESS_BASE`, 2: level L allows `GUESS_BASE+L` guesses.
- `TIMER_W`, 7: timer width; must hold `TIME_STEP*NUM_LEVELS`.
- `GUESS_W`, 4: guess-count width; must hold `GUESS_BASE+NUM_LEVELS`.
- `LEVEL_W`, 2: level/digit/round width; must hold `max(NUM_LEVELS, ROUNDS_PER_LEVEL)`.

Ports:
- `clk`, in, 1: system clock.
- `restart`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; begins a new game from IDLE, WIN or GAMEOVER.
- `tick`, in, 1: one-cycle 1 Hz enable from the prescaler.
- `confirm`, in, 1: one-cycle pulse; the player committed a guess.
- `correct`, in, 1: guess matched; qualified by `confirm` only.
- `state`, out, 3: IDLE=0, PLAY=1, WIN=2, GAMEOVER=3.
- `level`, out, LEVEL_W: current level, 1..NUM_LEVELS; 0 outside PLAY.
- `max_timer`, out, TIMER_W: `TIME_STEP*level`; 0 outside PLAY.
- `max_guess`, out, GUESS_W: `GUESS_BASE+level`; 0 outside PLAY.
- `max_digit`, out, LEVEL_W: equal to `level`; 0 outside PLAY.
- `time_left`, out, TIMER_W: remaining seconds in the current round.
- `guesses_left`, out, GUESS_W: remaining guesses in the current round.
- `round_cnt`, out, LEVEL_W: rounds cleared in the current level.
- `round_done`, out, 1: one-cycle pulse when a round is cleared.

## Operation
- State machine with four states: IDLE, PLAY, WIN, GAMEOVER.
- Registered state: `state`, `level`, `time_left`, `guesses_left`, `round_cnt` and `round_done`.
- `max_*` outputs are a combinational decode of `level` and `state`.

Round load:
- `time_left <= TIME_STEP*L`.
- `guesses_left <= GUESS_BASE+L`.

IDLE:
- All counters are 0.
- `start` → PLAY; `level <= 1`; `round_cnt <= 0`; round load for level 1.

PLAY, events in priority order:
1. `confirm && correct`:
   - `round_done` pulses.
   - If `round_cnt+1 < ROUNDS_PER_LEVEL`: `round_cnt` increments; round load at the same level.
   - Else if `level < NUM_LEVELS`: `level` increments; `round_cnt <= 0`; round load at the new level.
   - Else → WIN.
   - A `tick` in the same cycle is discarded.
2. `confirm && !correct`:
   - `guesses_left` decrements.
   - If it was 1 → GAMEOVER.
3. `tick`:
   - `time_left` decrements; it never goes below 0.
   - If it was 1 → GAMEOVER.
   - `tick` and wrong `confirm` in the same cycle both apply, so both counters decrement.
- `start` is ignored in PLAY.

WIN and GAMEOVER:
- Counters freeze at their last values.
- `confirm` and `tick` are ignored.
- `start` → PLAY at level 1 with a fresh round load.

Reset:
- `restart` low forces `state`=IDLE and every output to 0 immediately, including mid-round.

Arithmetic:
- Multiplication by `TIME_STEP` uses a constant per-level lookup; no runtime multiplier.
- All counters are unsigned and saturate at 0.

## Timing
- Every event takes effect on the same `clk` edge that samples it.
- Registered outputs update one cycle after the input pulse is asserted.
- `round_done` is high for exactly one cycle, coincident with the round load.
- `max_*` follow `level` with zero extra latency.
- GAMEOVER and WIN are entered on the edge that samples the terminating event.
- Reset assertion is asynchronous. Deassertion must be synchronised upstream; the block changes nothing until the first `start`.
- Inputs held high for several cycles are treated as repeated events; upstream must deliver single-cycle pulses.

## Test plan
- Reset mid-PLAY: in level 2, drive `restart` low between clock edges → all outputs 0 before the next edge; `state`=IDLE.
- Full win (defaults): `start`, then 9× `confirm`+`correct` → `max_timer` steps 30→60→90, `max_guess` 3→4→5, `max_digit` 1→2→3; `round_done` pulses 9 times; `state`=WIN after the 9th.
- Guess exhaustion at level 1: `start`, then 3× `confirm` with `correct`=0 → `guesses_left` 3→2→1→0; `state`=GAMEOVER on the 3rd; a following `tick` leaves `time_left`=30.
- Timeout: `start`, then 30 `tick`s → `time_left` reaches 0 and `state`=GAMEOVER on the 30th; then `start` → PLAY, `level`=1, `time_left`=30.
- Simultaneous events: with `time_left`=1, same-cycle `tick`+`confirm`+`correct` → round cleared, `time_left`=30, still PLAY. With `time_left`=1 and `guesses_left`=2, same-cycle `tick`+wrong `confirm` → GAMEOVER.
- Parameter sweep: `NUM_LEVELS`=4, `ROUNDS_PER_LEVEL`=1, `TIME_STEP`=15, `TIMER_W`=6 → four correct confirms reach WIN; `max_timer` is 15, 30, 45, 60.
